instr_fetch: RTL

- Fetch stage sitting directly upstream of the instruction decode Controller.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Delivers 32-bit instructions to decode over a valid/ready handshake and absorbs backpressure with a one-entry skid buffer.
- Stops fetching after a HALT instruction: opcode field bits [18:15] == 4'b1111, which the decoder already treats as non-writing.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 55 +++++
 rtl/instr_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and the decoder.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Opcode field position and the opcodes fetch/decode care about.
  localparam int         OPC_MSB   = 18;
  localparam int         OPC_LSB   = 15;
  localparam logic [3:0] OPC_HALT  = 4'b1111;
  localparam logic [3:0] OPC_STORE = 4'b0110;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  // True when the instruction's opcode field encodes HALT.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
// load_i has priority over unload_i so a simultaneous unload/refill keeps it full.
module fetch_skid_buf #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  // Next-state: capture on load, empty on unload, otherwise hold.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      pc_d   = pc_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= {INSTR_W{1'b0}};
      pc_q   <= {ADDR_W{1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency imem and
// hands instructions to decode over valid/ready with a one-entry skid buffer.
// Fetch stops after a HALT opcode and reports halted once fully drained.
// Optional performance counters are enabled with the macro IFETCH_PERF_CNT_EN.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        fetched_count
`endif
);

  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               rd_pending_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

  logic               skid_full_s, skid_load_s, skid_unload_s, skid_full_next_s;
  logic [INSTR_W-1:0] skid_data_s;
  logic [ADDR_W-1:0]  skid_pc_s;
  logic               accept_s, ret_s, out_free_s, issue_s;

  // Reads returning after HALT was seen are dropped by gating on FETCH.
  assign accept_s      = out_valid_q & instr_ready;
  assign ret_s         = rd_pending_q & (state_q == FETCH);
  assign out_free_s    = ~out_valid_q | accept_s;
  assign skid_unload_s = accept_s & skid_full_s;
  assign skid_load_s   = ret_s & (~out_free_s | skid_full_s);
  assign skid_full_next_s = skid_load_s | (skid_full_s & ~skid_unload_s);
  // Never issue while the skid is occupied or about to be filled, so the
  // read returning next cycle always has a free slot.
  assign issue_s       = (state_q == FETCH) & ~skid_full_s & ~skid_load_s;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load_s),
    .unload_i (skid_unload_s),
    .data_i   (imem_rdata),
    .pc_i     (rd_addr_q),
    .full_o   (skid_full_s),
    .data_o   (skid_data_s),
    .pc_o     (skid_pc_s)
  );

  // Out register: refill from skid first, else from returning data, else drain on accept.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    if (out_free_s) begin
      if (skid_full_s) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_s;
        out_pc_d    = skid_pc_s;
      end else if (ret_s) begin
        out_valid_d = 1'b1;
        out_data_d  = imem_rdata;
        out_pc_d    = rd_addr_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FSM next state and PC advance.
  always_comb begin
    state_d = state_q;
    if (issue_s) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
    case (state_q)
      FETCH: begin
        if (ret_s && is_halt(imem_rdata)) begin
          state_d = HALT_DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      HALT_DRAIN: begin
        if (!out_valid_d && !skid_full_next_s) begin
          state_d = HALTED;
        end else begin
          state_d = HALT_DRAIN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // State, PC, read tracking and out register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= {ADDR_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {INSTR_W{1'b0}};
      out_pc_q     <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_pending_q <= issue_s;
      rd_addr_q    <= issue_s ? pc_q : rd_addr_q;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd_en  = issue_s & ~rst;
  assign instr_out   = out_data_q;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_valid_q;
  assign halted      = (state_q == HALTED);

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fetch_cnt_q;

  // Saturating stall and accepted-instruction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      if (out_valid_q && !instr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (accept_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign fetched_count = fetch_cnt_q;
`endif

endmodule
